// File: rtl/path_replay_if.sv
`timescale 1ns/1ps
// Direction-buffer and move-consumer handshake bundle for the path replay controller.
// master = the controller, slave = buffer/consumer side.
interface path_replay_if #(
  parameter int COORD_W = 4
) ();
  logic               buf_empty;
  logic               dir_rd;
  logic               dir_valid;
  logic [1:0]         dir_in;
  logic               dir_last;
  logic               move_valid;
  logic               move_ready;
  logic [COORD_W-1:0] x_out;
  logic [COORD_W-1:0] y_out;

  modport master (
    output dir_rd, move_valid, x_out, y_out,
    input  buf_empty, dir_valid, dir_in, dir_last, move_ready
  );

  modport slave (
    input  dir_rd, move_valid, x_out, y_out,
    output buf_empty, dir_valid, dir_in, dir_last, move_ready
  );
endinterface

// File: rtl/path_replay_ctrl.sv
`timescale 1ns/1ps
// Replays a stored path of 2-bit direction codes as a stream of (x,y) cells,
// with bounds checking, a saturating move counter and done/err status.
module path_replay_ctrl #(
  parameter int COORD_W = 4,
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  path_replay_if.master    bus,
  output logic [CNT_W-1:0] move_count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_DIR = 3'd2,
    S_APPLY    = 3'd3,
    S_PRESENT  = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_e;

  localparam logic [COORD_W:0]   GRID_W_X = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0]   GRID_H_X = (COORD_W+1)'(GRID_H);
  localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [COORD_W:0]   ONE_X    = (COORD_W+1)'(1);

  state_e             state_r;
  state_e             state_s;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         dir_r;
  logic               last_r;
  logic               move_valid_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic [COORD_W:0]   nx_s;
  logic [COORD_W:0]   ny_s;
  logic               viol_s;
  logic               dir_rd_s;

  // Next coordinate with one guard bit so underflow/overflow shows up as out-of-range.
  always_comb begin
    nx_s = {1'b0, x_r};
    ny_s = {1'b0, y_r};
    case (dir_r)
      2'b00:   ny_s = {1'b0, y_r} - ONE_X;
      2'b01:   nx_s = {1'b0, x_r} + ONE_X;
      2'b10:   nx_s = {1'b0, x_r} - ONE_X;
      2'b11:   ny_s = {1'b0, y_r} + ONE_X;
      default: ny_s = {1'b0, y_r};
    endcase
    if ((nx_s >= GRID_W_X) || (ny_s >= GRID_H_X)) begin
      viol_s = 1'b1;
    end else begin
      viol_s = 1'b0;
    end
  end

  // Next-state decode; the buffer pop is requested only from FETCH with data available.
  always_comb begin
    state_s  = state_r;
    dir_rd_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_s = S_FETCH;
        end else begin
          state_s = state_r;
        end
      end
      S_FETCH: begin
        if (bus.buf_empty) begin
          // Empty on the very first fetch is a legal zero-length path.
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ERROR;
          end
        end else begin
          dir_rd_s = 1'b1;
          state_s  = S_WAIT_DIR;
        end
      end
      S_WAIT_DIR: begin
        if (bus.dir_valid) begin
          state_s = S_APPLY;
        end else begin
          state_s = S_WAIT_DIR;
        end
      end
      S_APPLY: begin
        if (viol_s) begin
          state_s = S_ERROR;
        end else begin
          state_s = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.move_ready) begin
          state_s = last_r ? S_DONE : S_FETCH;
        end else begin
          state_s = S_PRESENT;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register and status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      move_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      move_valid_r <= (state_s == S_PRESENT);
      busy_r       <= !((state_s == S_IDLE) || (state_s == S_DONE) || (state_s == S_ERROR));
      done_r       <= (state_s == S_DONE);
      err_r        <= (state_s == S_ERROR);
    end
  end

  // Coordinate, counter and latched direction datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r    <= START_XC;
      y_r    <= START_YC;
      cnt_r  <= {CNT_W{1'b0}};
      dir_r  <= 2'b00;
      last_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            x_r   <= START_XC;
            y_r   <= START_YC;
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        S_WAIT_DIR: begin
          if (bus.dir_valid) begin
            dir_r  <= bus.dir_in;
            last_r <= bus.dir_last;
          end
        end
        S_APPLY: begin
          if (!viol_s) begin
            x_r <= nx_s[COORD_W-1:0];
            y_r <= ny_s[COORD_W-1:0];
          end
        end
        S_PRESENT: begin
          if (bus.move_ready && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.dir_rd     = dir_rd_s;
  assign bus.move_valid = move_valid_r;
  assign bus.x_out      = x_r;
  assign bus.y_out      = y_r;
  assign move_count     = cnt_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;

endmodule

// File: tb/tb_path_replay_ctrl.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for path_replay_ctrl: a path-walking model predicts
// the accepted cell sequence and final status; a monitor checks each accepted move.
module tb_path_replay_ctrl;

  localparam int GW = 16;
  localparam int GH = 16;

  typedef struct { logic [1:0] d; logic l; } ent_t;
  typedef struct { int x; int y; } xy_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] move_count;
  logic       busy, done, err;

  path_replay_if #(.COORD_W(4)) bus ();

  path_replay_ctrl #(
    .COORD_W(4), .GRID_W(GW), .GRID_H(GH),
    .START_X(0), .START_Y(0), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .move_count(move_count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t bq[$];
  ent_t pth[$];
  xy_t  exp_q[$];
  int   pops = 0;
  int   wait_cnt = 0;
  int   delay_mode = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Direction buffer: answers each dir_rd with one entry 1..3 cycles later.
  initial begin
    logic rd;
    ent_t pend;
    bus.buf_empty = 1'b1;
    bus.dir_valid = 1'b0;
    bus.dir_in    = 2'b00;
    bus.dir_last  = 1'b0;
    forever begin
      @(negedge clk);
      rd = bus.dir_rd;
      bus.dir_valid = 1'b0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.dir_valid = 1'b1;
          bus.dir_in    = pend.d;
          bus.dir_last  = pend.l;
        end
      end
      bus.buf_empty = (bq.size() == 0);
      if (rd && !rst) begin
        pops++;
        if (bq.size() > 0) begin
          pend = bq.pop_front();
          wait_cnt = (delay_mode != 0) ? int'($urandom_range(1, 3)) : 1;
        end
      end
    end
  end

  // Consumer ready driver.
  initial begin
    bus.move_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.move_ready = 1'b1;
        1:       bus.move_ready = ($urandom_range(0, 2) != 0);
        default: bus.move_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks hold-stability while stalled and pops the scoreboard on acceptance.
  initial begin
    logic held_v;
    int   hx, hy;
    xy_t  e;
    held_v = 1'b0;
    hx = 0;
    hy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else if (bus.move_valid) begin
        if (held_v) begin
          chk("hold_x", int'(bus.x_out), hx);
          chk("hold_y", int'(bus.y_out), hy);
        end
        if (bus.move_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_move: got (%0d,%0d) expected none", bus.x_out, bus.y_out);
          end else begin
            e = exp_q.pop_front();
            chk("move_x", int'(bus.x_out), e.x);
            chk("move_y", int'(bus.y_out), e.y);
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          hx = int'(bus.x_out);
          hy = int'(bus.y_out);
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic mk(input int d, input bit l);
    ent_t e;
    e.d = 2'(d);
    e.l = l;
    pth.push_back(e);
  endtask

  // Walks the path on the grid, queues the expected cells and runs the DUT over it.
  task automatic run_path(input string tag, output int cyc);
    int  x, y, nx, ny, cnt, npops;
    bit  e_done, e_err, stop;
    xy_t c;
    x = 0; y = 0; cnt = 0; npops = 0;
    e_done = 1'b0; e_err = 1'b0; stop = 1'b0;
    for (int i = 0; i < pth.size() && !stop; i++) begin
      nx = x; ny = y;
      case (int'(pth[i].d))
        0: ny = y - 1;
        1: nx = x + 1;
        2: nx = x - 1;
        default: ny = y + 1;
      endcase
      npops = i + 1;
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
        e_err = 1'b1;
        stop = 1'b1;
      end else begin
        x = nx; y = ny; cnt++;
        c.x = x; c.y = y;
        exp_q.push_back(c);
        if (pth[i].l) begin
          e_done = 1'b1;
          stop = 1'b1;
        end
      end
    end
    if (!stop) begin
      if (cnt == 0) e_done = 1'b1;
      else          e_err = 1'b1;
    end
    bq = pth;
    pops = 0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (busy && cyc < 3000);
    if (cyc >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", tag, cyc);
    end
    chk({tag, "_done"}, int'(done), int'(e_done));
    chk({tag, "_err"}, int'(err), int'(e_err));
    chk({tag, "_count"}, int'(move_count), cnt);
    chk({tag, "_x"}, int'(bus.x_out), x);
    chk({tag, "_y"}, int'(bus.y_out), y);
    chk({tag, "_pops"}, pops, npops);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_mv"}, int'(bus.move_valid), 0);
    exp_q.delete();
    pth.delete();
  endtask

  initial begin
    int cyc;
    int n;
    bit has_last;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mv", int'(bus.move_valid), 0);
    chk("rst_x", int'(bus.x_out), 0);
    chk("rst_y", int'(bus.y_out), 0);
    chk("rst_cnt", int'(move_count), 0);
    chk("rst_status", int'({busy, done, err, bus.dir_rd}), 0);

    // Zero-length path: done right after FETCH, no pops.
    run_path("empty", cyc);
    chk("empty_lat", cyc, 1);

    // Reference path with fixed 1-cycle buffer latency: 4 cycles per move.
    mk(1, 0); mk(1, 0); mk(3, 0); mk(3, 0); mk(3, 1);
    run_path("ref", cyc);
    chk("ref_lat", cyc, 20);

    // Same path with a stalling consumer and variable buffer latency.
    ready_mode = 1; delay_mode = 1;
    mk(1, 0); mk(1, 0); mk(3, 0); mk(3, 0); mk(3, 1);
    run_path("stall", cyc);

    // Upward move from the top row is a violation.
    mk(0, 0); mk(1, 1);
    run_path("up0", cyc);
    mk(2, 1);
    run_path("left0", cyc);

    // Buffer runs dry without a last flag.
    mk(1, 0); mk(3, 0); mk(1, 0);
    run_path("dry", cyc);

    // Right and bottom edges.
    for (int i = 0; i < 16; i++) mk(1, 0);
    run_path("redge", cyc);
    for (int i = 0; i < 15; i++) mk(1, 0);
    for (int i = 0; i < 16; i++) mk(3, 0);
    run_path("bedge", cyc);

    // Reset while a move is stalled in PRESENT.
    ready_mode = 2;
    bq.delete();
    bq.push_back('{2'b01, 1'b0});
    bq.push_back('{2'b11, 1'b1});
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!bus.move_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_present", int'(bus.move_valid), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_mv", int'(bus.move_valid), 0);
    chk("mid_rst_x", int'(bus.x_out), 0);
    chk("mid_rst_y", int'(bus.y_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cnt", int'(move_count), 0);
    rst = 1'b0;
    bq.delete();
    exp_q.delete();
    wait_cnt = 0;
    ready_mode = 0;
    delay_mode = 0;
    mk(1, 0); mk(3, 0); mk(1, 1);
    run_path("after_rst", cyc);

    // Randomized paths, biased toward right/down so many complete.
    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(0, 12));
      has_last = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) != 0) mk(($urandom_range(0, 1) != 0) ? 1 : 3, has_last && (i == n - 1));
        else mk(int'($urandom_range(0, 3)), has_last && (i == n - 1));
      end
      ready_mode = int'($urandom_range(0, 1));
      delay_mode = int'($urandom_range(0, 1));
      run_path("rand", cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
